pipe_control: RTL
=================

# pipe_control

Pipelined successor of the single-cycle main decoder: decodes the RV64 subset (R-format, addi, ld, sd, beq) in ID and carries the control bits through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards, generates EX operand forwarding selects, kills wrong-path instructions on a taken branch and keeps saturating stall/flush event counters. Sits beside the 5-stage datapath; the datapath owns data registers, this block owns all control state.

## Interface
- REG_AW, 5: register-index width.
- BRANCH_STAGE, 1: 0 = beq resolved in ID, 1 = resolved in EX.
- CNT_W, 16: width of event counters.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  ID holds a real instruction.
- opcode_i  in  7  ID opcode.
- rs1_i, rs2_i, rd_i  in  REG_AW each  ID register fields.
- branch_taken_i  in  1  beq in BRANCH_STAGE compares equal.
- stall_o  out  1  hold PC and IF/ID (combinational).
- flush_o  out  1  squash IF/ID contents (combinational).
- illegal_o  out  1  registered pulse: valid unknown opcode left ID.
- ex_alusrc_o  out  1; ex_aluop_o  out  2  EX controls.
- fwd_a_o, fwd_b_o  out  2 each  EX operand select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- mem_memwr_o, mem_memrd_o  out  1 each  MEM controls.
- wb_memtoreg_o, wb_regwr_o  out  1 each; wb_rd_o  out  REG_AW  WB controls.
- stall_cnt_o, flush_cnt_o  out  CNT_W each  event counters.

## Operation
- Decode (ID, for valid_i=1): R 0110011 -> aluop 10, regwr; addi 0010011 -> alusrc, aluop 11, regwr; ld 0000011 -> alusrc, aluop 00, memrd, memtoreg, regwr; sd 0100011 -> alusrc, aluop 00, memwr; beq 1100011 -> aluop 01, branch. Any other opcode: all controls 0, illegal flag set. valid_i=0: all controls 0, no illegal flag.
- Source use: rs1 used by all five; rs2 used by R, sd, beq.
- Load-use: stall_o=1 when EX is a load, ex_rd!=0, and ex_rd equals a used ID source. ID/EX loads a bubble (all controls 0, illegal clear); EX/MEM and MEM/WB always advance.
- Forwarding for each EX source: MEM stage regwr & mem_rd!=0 & match -> 10; else WB regwr & wb_rd!=0 & match -> 01; else 00. MEM priority over WB. x0 never forwarded.
- Branch, BRANCH_STAGE=1: flush_o = EX holds beq & branch_taken_i; ID/EX also receives a bubble. Flush overrides a simultaneous stall (stall_o forced 0).
- Branch, BRANCH_STAGE=0: flush_o = ID holds beq & branch_taken_i & ~stall_o; a stalled beq ignores branch_taken_i. beq itself advances to EX.
- Counters: +1 per cycle with stall_o (resp. flush_o) high; saturate at all-ones.

## Timing
- Pipeline registers update on rising clk_i; control reaches ex_* 1 cycle, mem_* 2 cycles, wb_* 3 cycles after ID.
- stall_o, flush_o, fwd_*: combinational from current-cycle state and ID inputs; no registered feedback loop.
- illegal_o asserts in the cycle the offending instruction sits in EX, for 1 cycle.
- rst_i asserted (any time, including mid-stall or mid-flush): all pipeline registers, all outputs and counters 0 immediately; first instruction after release reaches EX one edge later.

## Test plan
- Reset: assert rst_i between edges mid-stream -> every output 0 at once; counters 0.
- Back-to-back: addi x5 then R add x6,x5,x5 -> cycle consumer in EX: fwd_a_o=fwd_b_o=10; one more instruction later consumer -> 01; rd=x0 producer -> 00.
- Load-use: ld x7 then sd using rs2=x7 -> stall_o=1 exactly one cycle, bubble in EX (all ex_* 0), then fwd_b_o=01; stall_cnt_o=1. Same with rs2 of addi (unused) -> no stall.
- Branch EX mode: beq taken with stall condition in ID same cycle -> flush_o=1, stall_o=0, bubble into EX, flush_cnt_o=1.
- Branch ID mode (BRANCH_STAGE=0): beq depending on ld in EX with branch_taken_i=1 -> cycle 1 stall_o=1 flush_o=0; cycle 2 flush_o=1.
- Opcode 1111111 valid -> illegal_o pulse 1 cycle later, no regwr/memwr ever; CNT_W=2 with 5 stalls -> stall_cnt_o holds 3.

Source files
------------

// File: rtl/pipe_control_if.sv
// Control-side bundle between the 5-stage datapath (master) and pipe_control (slave).
interface pipe_control_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              valid_i;
  logic [6:0]        opcode_i;
  logic [REG_AW-1:0] rs1_i, rs2_i, rd_i;
  logic              branch_taken_i;
  logic              stall_o, flush_o, illegal_o;
  logic              ex_alusrc_o;
  logic [1:0]        ex_aluop_o;
  logic [1:0]        fwd_a_o, fwd_b_o;
  logic              mem_memwr_o, mem_memrd_o;
  logic              wb_memtoreg_o, wb_regwr_o;
  logic [REG_AW-1:0] wb_rd_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  modport master (
    output valid_i, opcode_i, rs1_i, rs2_i, rd_i, branch_taken_i,
    input  stall_o, flush_o, illegal_o, ex_alusrc_o, ex_aluop_o, fwd_a_o, fwd_b_o,
           mem_memwr_o, mem_memrd_o, wb_memtoreg_o, wb_regwr_o, wb_rd_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  valid_i, opcode_i, rs1_i, rs2_i, rd_i, branch_taken_i,
    output stall_o, flush_o, illegal_o, ex_alusrc_o, ex_aluop_o, fwd_a_o, fwd_b_o,
           mem_memwr_o, mem_memrd_o, wb_memtoreg_o, wb_regwr_o, wb_rd_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_control.sv
// Pipelined RV64-subset control: ID decode, ID/EX/MEM/WB control registers,
// load-use stall, EX forwarding selects, branch flush and saturating event counters.

module pipe_fwd_sel #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              mem_regwr,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwr,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        sel
);
  // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
  always_comb begin
    sel = 2'b00;
    if (mem_regwr && mem_rd != '0 && mem_rd == src)   sel = 2'b10;
    else if (wb_regwr && wb_rd != '0 && wb_rd == src) sel = 2'b01;
  end
endmodule

module pipe_control #(
  parameter int REG_AW       = 5,
  parameter int BRANCH_STAGE = 1,
  parameter int CNT_W        = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  pipe_control_if.slave bus
);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       memrd, memwr, memtoreg, regwr, branch, illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             c;
    logic [REG_AW-1:0] rs1, rs2, rd;
  } idex_t;

  typedef struct packed {
    logic              memrd, memwr, memtoreg, regwr;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic              memtoreg, regwr;
    logic [REG_AW-1:0] rd;
  } memwb_t;

  ctrl_t  id_c;
  logic   use_rs1, use_rs2;
  idex_t  ex_q;
  exmem_t mem_q;
  memwb_t wb_q;
  logic   load_use, stall, flush, bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_comb begin
    id_c    = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (bus.valid_i) begin
      use_rs1 = 1'b1;
      case (bus.opcode_i)
        OP_R:    begin id_c.aluop = 2'b10; id_c.regwr = 1'b1; use_rs2 = 1'b1; end
        OP_ADDI: begin id_c.alusrc = 1'b1; id_c.aluop = 2'b11; id_c.regwr = 1'b1; end
        OP_LD:   begin
          id_c.alusrc = 1'b1; id_c.memrd = 1'b1; id_c.memtoreg = 1'b1; id_c.regwr = 1'b1;
        end
        OP_SD:   begin id_c.alusrc = 1'b1; id_c.memwr = 1'b1; use_rs2 = 1'b1; end
        OP_BEQ:  begin id_c.aluop = 2'b01; id_c.branch = 1'b1; use_rs2 = 1'b1; end
        default: begin id_c.illegal = 1'b1; use_rs1 = 1'b0; end
      endcase
    end
  end

  assign load_use = ex_q.c.memrd && ex_q.rd != '0 &&
                    ((use_rs1 && bus.rs1_i == ex_q.rd) || (use_rs2 && bus.rs2_i == ex_q.rd));

  generate
    if (BRANCH_STAGE == 1) begin : g_br_ex
      // Taken beq in EX kills the ID instruction, which would otherwise be stalled.
      assign flush  = ~rst_i & ex_q.c.branch & bus.branch_taken_i;
      assign stall  = ~rst_i & load_use & ~flush;
      assign bubble = stall | flush;
    end else begin : g_br_id
      // A stalled beq compares stale operands, so its outcome is ignored.
      assign stall  = ~rst_i & load_use;
      assign flush  = ~rst_i & id_c.branch & bus.branch_taken_i & ~stall;
      assign bubble = stall;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bubble) begin
        ex_q <= '0;
      end else begin
        ex_q.c   <= id_c;
        ex_q.rs1 <= bus.rs1_i;
        ex_q.rs2 <= bus.rs2_i;
        ex_q.rd  <= bus.rd_i;
      end
      mem_q.memrd    <= ex_q.c.memrd;
      mem_q.memwr    <= ex_q.c.memwr;
      mem_q.memtoreg <= ex_q.c.memtoreg;
      mem_q.regwr    <= ex_q.c.regwr;
      mem_q.rd       <= ex_q.rd;
      wb_q.memtoreg  <= mem_q.memtoreg;
      wb_q.regwr     <= mem_q.regwr;
      wb_q.rd        <= mem_q.rd;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  logic [1:0][REG_AW-1:0] ex_src;
  logic [1:0][1:0]        fwd;

  assign ex_src = {ex_q.rs2, ex_q.rs1};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_fwd
      pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd (
        .src       (ex_src[i]),
        .mem_regwr (mem_q.regwr),
        .mem_rd    (mem_q.rd),
        .wb_regwr  (wb_q.regwr),
        .wb_rd     (wb_q.rd),
        .sel       (fwd[i])
      );
    end
  endgenerate

  assign bus.stall_o       = stall;
  assign bus.flush_o       = flush;
  assign bus.illegal_o     = ex_q.c.illegal;
  assign bus.ex_alusrc_o   = ex_q.c.alusrc;
  assign bus.ex_aluop_o    = ex_q.c.aluop;
  assign bus.fwd_a_o       = fwd[0];
  assign bus.fwd_b_o       = fwd[1];
  assign bus.mem_memwr_o   = mem_q.memwr;
  assign bus.mem_memrd_o   = mem_q.memrd;
  assign bus.wb_memtoreg_o = wb_q.memtoreg;
  assign bus.wb_regwr_o    = wb_q.regwr;
  assign bus.wb_rd_o       = wb_q.rd;
  assign bus.stall_cnt_o   = stall_cnt;
  assign bus.flush_cnt_o   = flush_cnt;
endmodule
